amp_seq_ctrl: RTL and testbench

Power sequencer and slew controller for the external class-D amplifier and the on-chip PWM generator. It turns a register-bank enable bit and target duty cycle into an ordered sequence: amplifier enable, settle, unmute, duty ramp-up, slew-limited tracking, ramp-down, mute, disable. It sits between the register bank (`sys_cfg` fields) and the `pwm` instance / `amp_nenable` / `amp_mute` pads in `toi2s_tt_top`, and replaces the direct `sys_cfg` → `duty_cycle` connection.

---
 rtl/amp_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_amp_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amp_seq_ctrl.sv
// amp_seq_ctrl: power sequencer and duty slew controller for the class-D amplifier
// and the PWM generator.
//
// Sequence: amplifier enable -> settle -> unmute -> duty ramp-up -> slew-limited
// tracking -> ramp-down -> mute hold -> disable. An amplifier fault forces the duty
// to zero and parks the block in FAULT until software drops enable_req.
//
// Ports:
//   clk          system clock
//   resetb       asynchronous active-low reset
//   enable_req   amplifier enable request (clk domain)
//   target_duty  requested PWM duty
//   amp_fault    active-high amplifier fault (already synchronised)
//   duty_out     duty to the PWM generator
//   amp_nenable  active-low amplifier enable
//   amp_mute     active-high amplifier mute
//   busy         high in any transitional state
//   state_mon    current state encoding

module amp_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned RAMP_DIV      = 256
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       enable_req,
    input  logic [7:0] target_duty,
    input  logic       amp_fault,
    output logic [7:0] duty_out,
    output logic       amp_nenable,
    output logic       amp_mute,
    output logic       busy,
    output logic [2:0] state_mon
);

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StSettle   = 3'd1,
        StRampUp   = 3'd2,
        StRun      = 3'd3,
        StRampDown = 3'd4,
        StMuteHold = 3'd5,
        StFault    = 3'd6
    } state_e;

    localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] DivMax     = 16'(RAMP_DIV - 1);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] presc_q;
    logic [7:0]  duty_d;
    logic        tick;
    logic [7:0]  duty_up;
    logic [7:0]  duty_dn;
    logic [7:0]  duty_toward;

    // Free-running prescaler; the tick is the wrap cycle, so RAMP_DIV=1 ticks every cycle.
    assign tick = (presc_q == DivMax);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            presc_q <= 16'd0;
        end else if (tick) begin
            presc_q <= 16'd0;
        end else begin
            presc_q <= presc_q + 16'd1;
        end
    end

    // Saturating single-LSB steps; duty never wraps in either direction.
    always_comb begin
        duty_up     = (duty_out != 8'hFF) ? duty_out + 8'd1 : duty_out;
        duty_dn     = (duty_out != 8'h00) ? duty_out - 8'd1 : duty_out;
        duty_toward = duty_out;
        if (duty_out < target_duty) begin
            duty_toward = duty_up;
        end else if (duty_out > target_duty) begin
            duty_toward = duty_dn;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_out;
        if (amp_fault && (state_q != StOff)) begin
            // Fault overrides every other transition and kills the duty at once.
            state_d = StFault;
            duty_d  = 8'd0;
        end else begin
            case (state_q)
                StOff: begin
                    duty_d = 8'd0;
                    if (enable_req && !amp_fault) begin
                        state_d = StSettle;
                        cnt_d   = SettleLoad;
                    end
                end
                StSettle: begin
                    if (!enable_req) begin
                        state_d = StMuteHold;
                        cnt_d   = SettleLoad;
                    end else if (cnt_q == 16'd0) begin
                        state_d = StRampUp;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                StRampUp: begin
                    if (!enable_req) begin
                        state_d = StRampDown;
                    end else if (duty_out == target_duty) begin
                        state_d = StRun;
                    end else if (tick) begin
                        duty_d = duty_toward;
                    end
                end
                StRun: begin
                    if (!enable_req) begin
                        state_d = StRampDown;
                    end else if (tick) begin
                        duty_d = duty_toward;
                    end
                end
                StRampDown: begin
                    if (enable_req) begin
                        state_d = StRampUp;
                    end else if (duty_out == 8'd0) begin
                        state_d = StMuteHold;
                        cnt_d   = SettleLoad;
                    end else if (tick) begin
                        duty_d = duty_dn;
                    end
                end
                StMuteHold: begin
                    if (cnt_q == 16'd0) begin
                        state_d = StOff;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                StFault: begin
                    duty_d = 8'd0;
                    // Exit needs software acknowledge: enable dropped and fault gone.
                    if (!enable_req && !amp_fault) begin
                        state_d = StOff;
                    end
                end
                default: begin
                    state_d = StOff;
                    cnt_d   = 16'd0;
                    duty_d  = 8'd0;
                end
            endcase
        end
    end

    // State, counter, duty and decoded outputs all registered together; the pad outputs
    // are decoded from the next state so they line up with state_mon.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= StOff;
            cnt_q       <= 16'd0;
            duty_out    <= 8'd0;
            amp_nenable <= 1'b1;
            amp_mute    <= 1'b1;
            busy        <= 1'b0;
            state_mon   <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            duty_out    <= duty_d;
            amp_nenable <= (state_d == StOff) || (state_d == StFault);
            amp_mute    <= !((state_d == StRampUp) || (state_d == StRun) ||
                             (state_d == StRampDown));
            busy        <= (state_d == StSettle) || (state_d == StRampUp) ||
                           (state_d == StRampDown) || (state_d == StMuteHold);
            state_mon   <= state_d;
        end
    end

endmodule

// File: tb/tb_amp_seq_ctrl.sv
// Scoreboard bench for amp_seq_ctrl: stimulus pushes the expected sequence of output
// snapshots (with timing windows); a monitor pops one entry per observed output change.
module tb_amp_seq_ctrl;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned DIV    = 4;

    logic       clk         = 1'b0;
    logic       resetb      = 1'b1;
    logic       enable_req  = 1'b0;
    logic [7:0] target_duty = 8'd0;
    logic       amp_fault   = 1'b0;
    logic [7:0] duty_out;
    logic       amp_nenable;
    logic       amp_mute;
    logic       busy;
    logic [2:0] state_mon;

    amp_seq_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .RAMP_DIV     (DIV)
    ) dut (
        .clk        (clk),
        .resetb     (resetb),
        .enable_req (enable_req),
        .target_duty(target_duty),
        .amp_fault  (amp_fault),
        .duty_out   (duty_out),
        .amp_nenable(amp_nenable),
        .amp_mute   (amp_mute),
        .busy       (busy),
        .state_mon  (state_mon)
    );

    always #5 clk = ~clk;

    // Snapshot layout: {state[2:0], duty[7:0], nenable, mute, busy}.
    // rel=1: lo/hi bound the cycles since the previous change; rel=0: absolute cycle.
    typedef struct {
        logic [13:0] snap;
        bit          rel;
        int          lo;
        int          hi;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          since = 0;
    int          t;
    int          c;
    bit          mon_en = 1'b0;
    logic [13:0] last_snap;
    logic [13:0] cur;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] mk(input int st, input int duty, input bit nen,
                                       input bit mute, input bit bsy);
        return {st[2:0], duty[7:0], nen, mute, bsy};
    endfunction

    task automatic push(input logic [13:0] s, input bit rel, input int lo, input int hi);
        exp_t x;
        x.snap = s;
        x.rel  = rel;
        x.lo   = lo;
        x.hi   = hi;
        exp_q.push_back(x);
    endtask

    // One entry per duty step from 'from' (exclusive) to 'to'; steps after the first
    // land exactly one tick period apart.
    task automatic push_steps(input int st, input int from, input int to, input bit frel,
                              input int flo, input int fhi);
        int d;
        bit first;
        bit b;
        d     = from;
        first = 1'b1;
        b     = (st != 3);
        while (d != to) begin
            d = (to > from) ? d + 1 : d - 1;
            if (first) push(mk(st, d, 1'b0, 1'b0, b), frel, flo, fhi);
            else push(mk(st, d, 1'b0, 1'b0, b), 1'b1, DIV, DIV);
            first = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {state_mon, duty_out, amp_nenable, amp_mute, busy};
                since++;
                if (cur !== last_snap) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_change: actual st=%0d duty=%0d nen=%b mute=%b busy=%b, required no change (cycle %0d)",
                                 cur[13:11], cur[10:3], cur[2], cur[1], cur[0], cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e.snap) begin
                            n_err++;
                            $display("FAIL value: actual st=%0d duty=%0d nen=%b mute=%b busy=%b, required st=%0d duty=%0d nen=%b mute=%b busy=%b (cycle %0d)",
                                     cur[13:11], cur[10:3], cur[2], cur[1], cur[0],
                                     e.snap[13:11], e.snap[10:3], e.snap[2], e.snap[1],
                                     e.snap[0], cyc);
                        end
                        n_cmp++;
                        t = e.rel ? since : cyc;
                        if (t < e.lo || t > e.hi) begin
                            n_err++;
                            $display("FAIL timing: actual %0d, required %0d..%0d (%s, st=%0d duty=%0d)",
                                     t, e.lo, e.hi, e.rel ? "cycles since last change" : "cycle",
                                     cur[13:11], cur[10:3]);
                        end
                    end
                    last_snap = cur;
                    since     = 0;
                end
            end
        end
    end

    task automatic check_reset(input string name);
        n_cmp++;
        if ({state_mon, duty_out, amp_nenable, amp_mute, busy} !== mk(0, 0, 1, 1, 0)) begin
            n_err++;
            $display("FAIL %s: actual st=%0d duty=%0d nen=%b mute=%b busy=%b, required st=0 duty=0 nen=1 mute=1 busy=0",
                     name, state_mon, duty_out, amp_nenable, amp_mute, busy);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: actual %0d entries pending, required 0", name,
                     exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_duty(input string name, input logic [7:0] val, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (duty_out !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (duty_out !== val) begin
            n_err++;
            $display("FAIL %s_timeout: actual duty %0d, required %0d", name, duty_out, val);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic power_up(input string name, input int tgt);
        target_duty = 8'(tgt);
        enable_req  = 1'b1;
        c = cyc;
        push(mk(1, 0, 0, 1, 1), 1'b0, c + 1, c + 1);
        push(mk(2, 0, 0, 0, 1), 1'b1, SETTLE, SETTLE);
        push_steps(2, 0, tgt, 1'b1, 1, DIV);
        push(mk(3, tgt, 0, 0, 0), 1'b1, 1, 1);
        wait_drain(name, 300);
    endtask

    initial begin
        #1 resetb = 1'b0;
        #1 check_reset("reset_values");
        repeat (2) @(posedge clk);
        #1;
        last_snap = mk(0, 0, 1, 1, 0);
        mon_en    = 1'b1;
        resetb    = 1'b1;
        idle(3);

        power_up("power_up", 10);

        // Power-down from RUN at duty 10.
        enable_req = 1'b0;
        c = cyc;
        push(mk(4, 10, 0, 0, 1), 1'b0, c + 1, c + 1);
        push_steps(4, 10, 0, 1'b1, 1, DIV);
        push(mk(5, 0, 0, 1, 1), 1'b1, 1, 1);
        push(mk(0, 0, 1, 1, 0), 1'b1, SETTLE, SETTLE);
        wait_drain("power_down", 300);
        idle(5);

        power_up("power_up_again", 10);

        // Slew down to 7 in RUN, then up to 255 with saturation.
        target_duty = 8'd7;
        c = cyc;
        push_steps(3, 10, 7, 1'b0, c + 1, c + DIV);
        wait_drain("slew_down", 100);
        target_duty = 8'd255;
        c = cyc;
        push_steps(3, 7, 255, 1'b0, c + 1, c + DIV);
        wait_drain("slew_up", 1100);
        idle(20);
        n_cmp++;
        if (duty_out !== 8'd255) begin
            n_err++;
            $display("FAIL saturate: actual duty %0d, required 255", duty_out);
        end

        // Ramp down from 255 and re-enable at duty 5.
        enable_req = 1'b0;
        c = cyc;
        push(mk(4, 255, 0, 0, 1), 1'b0, c + 1, c + 1);
        push_steps(4, 255, 5, 1'b1, 1, DIV);
        wait_duty("reach_5", 8'd5, 1200);
        @(posedge clk);
        #1;
        enable_req  = 1'b1;
        target_duty = 8'd10;
        c = cyc;
        push(mk(2, 5, 0, 0, 1), 1'b0, c + 1, c + 1);
        push_steps(2, 5, 10, 1'b1, 1, DIV);
        push(mk(3, 10, 0, 0, 0), 1'b1, 1, 1);
        wait_drain("reenable", 100);

        // Fault pulse in RUN; FAULT holds while enable_req stays high.
        amp_fault = 1'b1;
        c = cyc;
        push(mk(6, 0, 1, 1, 0), 1'b0, c + 1, c + 1);
        @(posedge clk);
        #1;
        amp_fault = 1'b0;
        idle(20);
        wait_drain("fault", 10);
        enable_req = 1'b0;
        c = cyc;
        push(mk(0, 0, 1, 1, 0), 1'b0, c + 1, c + 1);
        wait_drain("fault_ack", 10);
        idle(3);

        // Reset during RAMP_UP at duty 3, then full restart.
        target_duty = 8'd10;
        enable_req  = 1'b1;
        c = cyc;
        push(mk(1, 0, 0, 1, 1), 1'b0, c + 1, c + 1);
        push(mk(2, 0, 0, 0, 1), 1'b1, SETTLE, SETTLE);
        push_steps(2, 0, 3, 1'b1, 1, DIV);
        wait_duty("reach_3", 8'd3, 100);
        #2;
        push(mk(0, 0, 1, 1, 0), 1'b1, 0, 1000000);
        resetb = 1'b0;
        #1 check_reset("async_reset");
        repeat (3) @(posedge clk);
        #1;
        c = cyc;
        push(mk(1, 0, 0, 1, 1), 1'b0, c + 1, c + 1);
        push(mk(2, 0, 0, 0, 1), 1'b1, SETTLE, SETTLE);
        push_steps(2, 0, 10, 1'b1, 1, DIV);
        push(mk(3, 10, 0, 0, 0), 1'b1, 1, 1);
        resetb = 1'b1;
        wait_drain("restart", 300);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
